// File: rtl/alarm_trigger_ctrl.sv
// Alarm trigger controller: time/alarm match detection and ring/snooze/stop FSM.
// Optional build macro SNOOZE_LIMIT_EN caps honoured snooze presses at MAX_SNOOZES.
module alarm_trigger_ctrl #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic [12:0] time_count,
    input  logic [12:0] alarm_count,
    input  logic        alarm_en,
    input  logic        snooze_btn,
    input  logic        stop_btn,
    output logic        buzzer,
    output logic        ringing,
    output logic        snoozed,
    output logic [1:0]  snooze_cnt
);

    localparam int MAX_S = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
    localparam int CNT_W = $clog2(MAX_S + 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             buzzer_q, buzzer_d;
    logic             ringing_q, ringing_d;
    logic             snoozed_q, snoozed_d;
    logic             match_q, match_d;

    logic match_rise;
    logic ring_done;
    logic snooze_done;
    logic snooze_blocked;
    logic [1:0] snooze_cap;

`ifdef SNOOZE_LIMIT_EN
    assign snooze_cap     = 2'(MAX_SNOOZES);
    assign snooze_blocked = (snooze_cnt_q == snooze_cap);
`else
    // Snoozes are unlimited here; the count is informational and saturates at 3.
    logic [31:0] unused_max_snoozes;
    assign unused_max_snoozes = 32'(MAX_SNOOZES);
    assign snooze_cap         = 2'd3;
    assign snooze_blocked     = 1'b0;
`endif

    assign match_d     = (time_count == alarm_count);
    assign match_rise  = match_d & ~match_q;
    assign ring_done   = sec_tick && (sec_cnt_q == RING_LAST);
    assign snooze_done = sec_tick && (sec_cnt_q == SNOOZE_LAST);

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        buzzer_d     = buzzer_q;

        case (state_q)
            IDLE: begin
                if (alarm_en) state_d = ARMED;
            end
            ARMED: begin
                if (!alarm_en) begin
                    state_d = IDLE;
                end else if (match_rise) begin
                    state_d   = RINGING;
                    sec_cnt_d = '0;
                    buzzer_d  = 1'b1;
                end
            end
            RINGING: begin
                if (!alarm_en) begin
                    state_d = IDLE;
                end else if (stop_btn || ring_done) begin
                    state_d = ARMED;
                end else if (snooze_btn && !snooze_blocked) begin
                    state_d      = SNOOZE;
                    sec_cnt_d    = '0;
                    snooze_cnt_d = (snooze_cnt_q == snooze_cap) ? snooze_cnt_q
                                                                : snooze_cnt_q + 2'd1;
                end else if (sec_tick) begin
                    sec_cnt_d = sec_cnt_q + 1'b1;
                    buzzer_d  = ~buzzer_q;
                end
            end
            SNOOZE: begin
                if (!alarm_en) begin
                    state_d = IDLE;
                end else if (stop_btn) begin
                    state_d = ARMED;
                end else if (snooze_done) begin
                    state_d   = RINGING;
                    sec_cnt_d = '0;
                    buzzer_d  = 1'b1;
                end else if (sec_tick) begin
                    sec_cnt_d = sec_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Leaving the ring/snooze cycle ends the alarm event: clear its bookkeeping.
        if (state_d == IDLE || state_d == ARMED) begin
            sec_cnt_d    = '0;
            snooze_cnt_d = 2'd0;
        end
        if (state_d != RINGING) buzzer_d = 1'b0;
        ringing_d = (state_d == RINGING);
        snoozed_d = (state_d == SNOOZE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sec_cnt_q    <= '0;
            snooze_cnt_q <= 2'd0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            snoozed_q    <= snoozed_d;
            match_q      <= match_d;
        end
    end

    assign buzzer     = buzzer_q;
    assign ringing    = ringing_q;
    assign snoozed    = snoozed_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// Scoreboard bench for alarm_trigger_ctrl: expected {ringing,snoozed,buzzer,snooze_cnt}
// is queued when each cycle's stimulus is driven and checked after the clock edge.
module tb_alarm_trigger_ctrl;

    localparam logic [12:0] T0729 = 13'b0_0111_010_1001;
    localparam logic [12:0] T0730 = 13'b0_0111_011_0000;
    localparam logic [12:0] T0731 = 13'b0_0111_011_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        sec_tick;
    logic [12:0] time_count;
    logic [12:0] alarm_count;
    logic        alarm_en;
    logic        snooze_btn;
    logic        stop_btn;
    logic        buzzer;
    logic        ringing;
    logic        snoozed;
    logic [1:0]  snooze_cnt;
    logic [4:0]  obs;

    logic [4:0] sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign obs = {ringing, snoozed, buzzer, snooze_cnt};

    alarm_trigger_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .time_count (time_count),
        .alarm_count(alarm_count),
        .alarm_en   (alarm_en),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .snooze_cnt (snooze_cnt)
    );

    function automatic logic [4:0] E(input logic r, input logic s, input logic b,
                                     input logic [1:0] c);
        return {r, s, b, c};
    endfunction

    // One clock cycle of stimulus; pulses are dropped again after the edge.
    task automatic step(input logic en, input logic [12:0] t, input logic tk,
                        input logic sz, input logic sp, input logic rn);
        alarm_en   = en;
        time_count = t;
        sec_tick   = tk;
        snooze_btn = sz;
        stop_btn   = sp;
        rst        = rn;
        @(posedge clk);
        #1;
        sec_tick   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        alarm_count = T0730;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(E(0, 0, 0, 2'd0));
            step(1'b0, T0729, 1'b1, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_state: got %b required %b", obs, e);
            end
        end
    endtask

    task automatic test_ring_basic();
        logic [4:0] e;
        string      nm [5] = '{"armed_quiet", "ring_latency", "buzz_tick1", "buzz_hold", "buzz_tick2"};
        logic [12:0] tt [5] = '{T0729, T0730, T0730, T0730, T0730};
        logic        tk [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0]  ex [5];
        ex = '{E(0,0,0,0), E(1,0,1,0), E(1,0,0,0), E(1,0,0,0), E(1,0,1,0)};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex[i]);
            step(1'b1, tt[i], tk[i], 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s: got %b required %b", nm[i], obs, e);
            end
        end
    endtask

    task automatic test_stop_no_retrigger();
        logic [4:0] e;
        logic [12:0] tt [7] = '{T0730, T0730, T0730, T0730, T0731, T0730, T0730};
        logic        sp [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0]  ex [7];
        ex = '{E(0,0,0,0), E(0,0,0,0), E(0,0,0,0), E(0,0,0,0), E(0,0,0,0), E(1,0,1,0), E(0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ex[i]);
            step(1'b1, tt[i], 1'b0, 1'b0, sp[i], 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL stop_retrigger[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] e;
        step(1'b1, T0731, 1'b0, 1'b0, 1'b0, 1'b1);
        // sec_tick coincides with ring entry and must not be counted
        sb.push_back(E(1, 0, 1, 2'd0));
        step(1'b1, T0730, 1'b1, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL entry_tick: got %b required %b", obs, e);
        end
        for (int i = 1; i <= 60; i++) begin
            sb.push_back((i < 60) ? E(1, 0, (i % 2 == 0), 2'd0) : E(0, 0, 0, 2'd0));
            step(1'b1, T0730, 1'b1, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL ring_tick%0d: got %b required %b", i, obs, e);
            end
        end
        step(1'b1, T0731, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.push_back(E(1, 0, 1, 2'd0));
        step(1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL armed_after_timeout: got %b required %b", obs, e);
        end
    endtask

    task automatic test_snooze();
        logic [4:0] e;
        for (int n = 1; n <= 4; n++) begin
`ifdef SNOOZE_LIMIT_EN
            sb.push_back((n <= 3) ? E(0, 1, 0, 2'(n)) : E(1, 0, 1, 2'd3));
`else
            sb.push_back((n <= 3) ? E(0, 1, 0, 2'(n)) : E(0, 1, 0, 2'd3));
`endif
            step(1'b1, T0730, 1'b0, 1'b1, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL snooze_press%0d: got %b required %b", n, obs, e);
            end
            if (n == 4) break;
            // a snooze press during SNOOZE (i==1) must be ignored
            for (int i = 1; i <= 300; i++) begin
                sb.push_back((i < 300) ? E(0, 1, 0, 2'(n)) : E(1, 0, 1, 2'(n)));
                step(1'b1, T0730, 1'b1, (i == 1), 1'b0, 1'b1);
                e = sb.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL snooze%0d_tick%0d: got %b required %b", n, i, obs, e);
                end
            end
        end
        sb.push_back(E(0, 0, 0, 2'd0));
        step(1'b1, T0730, 1'b0, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL stop_after_snoozes: got %b required %b", obs, e);
        end
    endtask

    task automatic test_stop_snooze_en_drop();
        logic [4:0] e;
        string       nm [12] = '{"pre", "ring", "stop_and_snooze", "pre2", "ring_again", "snooze",
                                 "en_drop_snooze", "idle_a", "idle_ignores_rise",
                                 "en_back_no_ring", "armed_no_rise", "pre3"};
        logic        en [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        logic [12:0] tt [12] = '{T0731, T0730, T0730, T0731, T0730, T0730,
                                 T0730, T0731, T0730, T0730, T0730, T0731};
        logic        sz [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic        sp [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [4:0]  ex [12];
        ex = '{E(0,0,0,0), E(1,0,1,0), E(0,0,0,0), E(0,0,0,0), E(1,0,1,0), E(0,1,0,1),
               E(0,0,0,0), E(0,0,0,0), E(0,0,0,0), E(0,0,0,0), E(0,0,0,0), E(0,0,0,0)};
        for (int i = 0; i < 12; i++) begin
            sb.push_back(ex[i]);
            step(en[i], tt[i], 1'b0, sz[i], sp[i], 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s: got %b required %b", nm[i], obs, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [4:0] e;
        step(1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b1);
        // en low beats stop/snooze; the machine must then be in IDLE, not ARMED
        sb.push_back(E(0, 0, 0, 2'd0));
        step(1'b0, T0731, 1'b1, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL en_low_priority: got %b required %b", obs, e);
        end
        sb.push_back(E(0, 0, 0, 2'd0));
        step(1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL went_idle: got %b required %b", obs, e);
        end
        step(1'b1, T0731, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 60; i++) step(1'b1, T0730, 1'b1, 1'b0, 1'b0, 1'b1);
        sb.push_back(E(0, 0, 0, 2'd0));
        step(1'b1, T0730, 1'b1, 1'b1, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL timeout_over_snooze: got %b required %b", obs, e);
        end
    endtask

    task automatic test_reset_mid_event();
        logic [4:0] e;
        string       nm [8] = '{"pre", "ring", "rst_mid_ring", "rst_release", "no_ring_without_rise",
                                "pre2", "fresh_rise", "snooze"};
        logic [12:0] tt [8] = '{T0731, T0730, T0730, T0730, T0730, T0731, T0730, T0730};
        logic        sz [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic        rn [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        logic [4:0]  ex [8];
        ex = '{E(0,0,0,0), E(1,0,1,0), E(0,0,0,0), E(0,0,0,0), E(0,0,0,0),
               E(0,0,0,0), E(1,0,1,0), E(0,1,0,1)};
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ex[i]);
            step(1'b1, tt[i], 1'b0, sz[i], 1'b0, rn[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s: got %b required %b", nm[i], obs, e);
            end
        end
        sb.push_back(E(0, 0, 0, 2'd0));
        step(1'b1, T0730, 1'b1, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL rst_mid_snooze: got %b required %b", obs, e);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        alarm_en    = 1'b0;
        sec_tick    = 1'b0;
        snooze_btn  = 1'b0;
        stop_btn    = 1'b0;
        time_count  = T0729;
        alarm_count = T0730;
        #2;
        test_reset();
        test_ring_basic();
        test_stop_no_retrigger();
        test_timeout();
        test_snooze();
        test_stop_snooze_en_drop();
        test_priority();
        test_reset_mid_event();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_trigger_ctrl.md
Name: alarm_trigger_ctrl

Overview:
- Read side of the alarm-setting path.
- Compares the live clock time against the stored alarm setting, both packed BCD in the same 13-bit format the alarm-adjust block produces.
- Runs the ring/snooze/stop state machine and drives the buzzer and status outputs.
- Sits between the timekeeping and alarm-adjust counters and the buzzer/LED pins.

Parameters:
- RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-stop.
- SNOOZE_S, 300, seconds spent in SNOOZE before re-ringing.
- MAX_SNOOZES, 3, snooze presses honoured per alarm event (used only with SNOOZE_LIMIT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- sec_tick  input  1  one-cycle pulse, once per second
- time_count  input  13  current time {hours_tens[12:11], hours[10:7], min_tens[6:4], min[3:0]}
- alarm_count  input  13  alarm setting, same packing
- alarm_en  input  1  arm switch, level
- snooze_btn  input  1  debounced single-cycle pulse
- stop_btn  input  1  debounced single-cycle pulse
- buzzer  output  1  beep drive
- ringing  output  1  high in RINGING
- snoozed  output  1  high in SNOOZE
- snooze_cnt  output  2  snoozes taken in the current alarm event

Behaviour:
- All outputs and state are registered. On rst==0 at a clk edge:
  - state=IDLE; buzzer, ringing, snoozed = 0; snooze_cnt=0; second counter=0; match_q=0.
  - Reset mid-ring or mid-snooze aborts immediately, with no residual output on the next cycle.
- Match detection:
  - match = (time_count == alarm_count), full 13-bit compare. match_q is match registered.
  - match_rise = match & ~match_q.
  - Alarm fires only on match_rise, so stopping inside the matching minute does not re-trigger.
- States: IDLE, ARMED, RINGING, SNOOZE.
- IDLE:
  - alarm_en=1 -> ARMED.
  - match_rise is ignored.
- ARMED:
  - match_rise -> RINGING. ringing=1 on the clock edge after the one where match first is true (1-cycle latency).
  - On entry: second counter=0, snooze_cnt=0.
- RINGING:
  - buzzer toggles on each sec_tick (1 s on / 1 s off) and starts at 1 on entry.
  - Counts sec_tick; reaching RING_TIMEOUT_S -> ARMED with buzzer=0.
  - stop_btn -> ARMED.
  - snooze_btn (no stop) -> SNOOZE; snooze_cnt increments, saturating at 3; second counter cleared.
- SNOOZE:
  - buzzer=0, snoozed=1.
  - Counts sec_tick; reaching SNOOZE_S -> RINGING, second counter cleared.
  - stop_btn -> ARMED.
  - snooze_btn is ignored.
- Any state except IDLE: alarm_en=0 -> IDLE next edge, all outputs 0. This has priority over stop, snooze and timeout.
- Simultaneous events, priority order: rst > alarm_en=0 > stop_btn > timeout > snooze_btn.
- alarm_count changes while in RINGING or SNOOZE have no effect until the machine returns to ARMED.
- A match_rise arriving while in RINGING or SNOOZE is ignored.
- sec_tick in the same cycle as state entry is not counted.
- The second counter is wide enough for max(RING_TIMEOUT_S, SNOOZE_S) and never wraps; it is cleared on every state entry.

Optional Feature:
- Macro: SNOOZE_LIMIT_EN.
- Defined:
  - In RINGING with snooze_cnt == MAX_SNOOZES, snooze_btn is ignored and ringing continues until stop or timeout.
  - snooze_cnt saturates at MAX_SNOOZES.
- Undefined:
  - Snoozes are unlimited.
  - snooze_cnt counts and saturates at 3 and is informational only.

Test Plan:
- Reset with rst=0 for 2 cycles, then alarm_en=1, alarm_count=07:30 (0_0111_011_0000), time steps 07:29 -> 07:30 -> ringing=1 exactly one cycle after time_count==alarm_count; buzzer pattern is 1,0,1 on successive sec_ticks.
- While ringing, assert stop_btn and keep time at 07:30 -> ARMED; no re-trigger while time stays 07:30. Then time goes 07:31, and is wrapped back to 07:30 -> rings again.
- Ring and issue no input for 60 sec_ticks -> ringing=0, buzzer=0, state ARMED.
- snooze_btn while ringing -> snoozed=1, snooze_cnt=1. After 300 sec_ticks -> ringing=1. With SNOOZE_LIMIT_EN and MAX_SNOOZES=3, the 4th snooze_btn is ignored (ringing stays 1, snooze_cnt=3).
- stop_btn and snooze_btn in the same cycle while ringing -> ARMED, snooze_cnt unchanged. alarm_en dropped while in SNOOZE -> all outputs 0 next cycle, state IDLE.
- rst=0 asserted mid-RINGING -> buzzer and ringing 0 on that edge. After release with alarm_en=1 -> ARMED, and no ring until a fresh match_rise.
